data_memory_sized: RTL and testbench
====================================

// Module: data_memory_sized
// PURPOSE
//  Second-generation processor data memory: byte-lane banked RAM with byte/half/word
//  access via size_in, registered reads, misalignment detection, and a memory-mapped
//  serial port with a TX FIFO so stores to the console do not stall on serial_ready_in.
//  Sits on the processor's load/store path; serial pins pass straight to the test bench.
// PARAMETERS
//  DEPTH_WORDS     1024          32-bit words of RAM (power of 2); RAM at byte addr 0..4*DEPTH_WORDS-1
//  TX_FIFO_DEPTH   8             serial TX FIFO entries (power of 2, >=2)
//  SERIAL_TX_ADDR  32'hFFFF_0000 store byte here -> pushed to TX FIFO
//  SERIAL_RX_ADDR  32'hFFFF_0004 load here -> pops one byte from serial_in
//  SERIAL_ST_ADDR  32'hFFFF_0008 load here -> status word
//  INIT_PROGRAM0..3 ""           hex files for byte lanes 0..3 ($readmemh); "" = no preload
// PORTS
//  clock            in   1   rising-edge clock
//  reset            in   1   asynchronous, active-low reset
//  addr_in          in   32  byte address
//  writedata_in     in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  re_in            in   1   load request
//  we_in            in   1   store request
//  size_in          in   2   00 byte, 01 half, 11 word, 10 reserved (treated as word)
//  readdata_out     out  32  load data, valid the cycle after re_in, zero-extended, right-justified
//  stall_out        out  1   comb.: store to SERIAL_TX_ADDR not accepted this cycle (FIFO full)
//  misalign_out     out  1   one-cycle pulse, cycle after a misaligned access
//  serial_in        in   8   RX byte from bench
//  serial_ready_in  in   1   bench can accept a TX byte
//  serial_valid_in  in   1   serial_in holds a valid RX byte
//  serial_out       out  8   TX byte to bench
//  serial_rden_out  out  1   one-cycle pulse: RX byte consumed
//  serial_wren_out  out  1   one-cycle pulse: serial_out valid, bench takes it
// BEHAVIOUR
//  Reset (async, reset=0): readdata_out=0, misalign_out=0, serial_out=0, serial_wren_out=0,
//   serial_rden_out=0, TX FIFO emptied (queued bytes discarded). RAM contents untouched.
//  Big-endian lanes: byte at addr A with A[1:0]=0 is writedata bits [31:24] of a word.
//  Alignment: half needs addr[0]=0, word needs addr[1:0]=0; violating access is dropped
//   (no write, readdata_out=0) and misalign_out=1 next cycle. Checked before any decode.
//  Store (we_in=1): RAM write at the edge, only selected lanes byte-enabled.
//  Load (re_in=1): readdata_out updated at next edge (latency 1); holds value when re_in=0.
//  re_in & we_in together: store performed, load ignored, readdata_out holds.
//  Unmapped address: stores ignored, loads return 0; no error flag.
//  SERIAL_TX_ADDR store (any size, data[7:0]): push if FIFO not full; if full, stall_out=1,
//   nothing pushed; processor holds the request until stall_out=0. Push and pop same
//   cycle on a full FIFO is NOT allowed (stall still asserted; stall_out from count only).
//  TX drain: when FIFO non-empty and serial_ready_in=1, next edge: serial_out<=head,
//   serial_wren_out<=1, pop. Otherwise serial_wren_out<=0. Max one byte per cycle.
//  SERIAL_RX_ADDR load: if serial_valid_in, readdata_out<={24'b0,serial_in} and
//   serial_rden_out=1 for that one cycle; else readdata_out<=32'hFFFF_FFFF, no rden.
//  SERIAL_ST_ADDR load: {16'b0, count[7:0], 5'b0, fifo_empty, fifo_full, serial_valid_in}.
//  FIFO pointers wrap modulo TX_FIFO_DEPTH; count width clog2(DEPTH)+1.
// STRUCTURE
//  Package data_memory_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), default serial addresses,
//   status bit positions.
//  Sub-module serial_tx_fifo (sync FIFO, push/pop/full/empty/count, async active-low reset).
//  RAM as four byte-lane arrays in the top level, one $readmemh per lane.
// TESTING
//  Word store 0xDEADBEEF @0x10, load word @0x10 -> readdata_out=0xDEADBEEF one cycle later.
//  Byte store 0xAA @0x13 over above, load byte @0x13 -> 0x000000AA; load word -> 0xDEADBEAA.
//  Half load @0x11 -> no RAM change, misalign_out=1 next cycle, readdata_out=0.
//  serial_ready_in=0, store 'H','i',... 9 bytes to TX with DEPTH 8 -> 9th sees stall_out=1;
//   raise ready -> bytes emerge in order, one wren pulse each, stall drops after first pop.
//  RX load with serial_valid_in=1, serial_in=0x41 -> readdata 0x41, rden pulse; valid=0 -> 0xFFFFFFFF.
//  Reset asserted with 3 bytes queued -> wren stays 0, status count reads 0 after release.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared encodings for the sized data memory: access sizes, default
// memory-mapped serial addresses and status word bit positions.
package data_memory_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_RSVD = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    localparam logic [31:0] DEF_SERIAL_TX_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] DEF_SERIAL_RX_ADDR = 32'hFFFF_0004;
    localparam logic [31:0] DEF_SERIAL_ST_ADDR = 32'hFFFF_0008;

    // Status word layout: {16'b0, count[7:0], 5'b0, empty, full, rx_valid}
    localparam int ST_VALID_BIT = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_EMPTY_BIT = 2;
    localparam int ST_COUNT_LSB = 8;

    // Halves need an even address, words (and the reserved size) a word address.
    function automatic logic is_aligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/data_memory_sized_fifo.sv
// Small synchronous FIFO that buffers console bytes so processor stores
// never wait on the serial sink. Pushes are refused when full and pops
// when empty, so a full FIFO never accepts a push even in a pop cycle.
module serial_tx_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage array: data only, never reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_memory_sized.sv
// Processor data memory: four big-endian byte lanes with byte/half/word
// access, one-cycle registered loads, misalignment flagging and a
// memory-mapped serial port whose TX side is buffered by a small FIFO.
module data_memory_sized
    import data_memory_pkg::*;
#(
    parameter int          DEPTH_WORDS    = 1024,
    parameter int          TX_FIFO_DEPTH  = 8,
    parameter logic [31:0] SERIAL_TX_ADDR = DEF_SERIAL_TX_ADDR,
    parameter logic [31:0] SERIAL_RX_ADDR = DEF_SERIAL_RX_ADDR,
    parameter logic [31:0] SERIAL_ST_ADDR = DEF_SERIAL_ST_ADDR,
    parameter string       INIT_PROGRAM0  = "",
    parameter string       INIT_PROGRAM1  = "",
    parameter string       INIT_PROGRAM2  = "",
    parameter string       INIT_PROGRAM3  = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr_in,
    input  logic [31:0] writedata_in,
    input  logic        re_in,
    input  logic        we_in,
    input  logic [1:0]  size_in,
    output logic [31:0] readdata_out,
    output logic        stall_out,
    output logic        misalign_out,
    input  logic [7:0]  serial_in,
    input  logic        serial_ready_in,
    input  logic        serial_valid_in,
    output logic [7:0]  serial_out,
    output logic        serial_rden_out,
    output logic        serial_wren_out
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

    // Lane 0 holds the most significant byte of each word (big-endian).
    logic [7:0] lane0 [DEPTH_WORDS];
    logic [7:0] lane1 [DEPTH_WORDS];
    logic [7:0] lane2 [DEPTH_WORDS];
    logic [7:0] lane3 [DEPTH_WORDS];

    size_e         sz;
    logic [1:0]    off;
    logic          aligned;
    logic          access;
    logic          do_store;
    logic          do_load;
    logic          in_ram;
    logic          tx_hit;
    logic          rx_hit;
    logic          st_hit;
    logic          ram_we;
    logic [AW-1:0] widx;
    logic [3:0]    be;
    logic [7:0]    wbyte [4];
    logic [7:0]    rb0, rb1, rb2, rb3;
    logic [31:0]   load_data;
    logic [31:0]   status;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;

    // Alignment is judged first; a misaligned access never reaches any decode.
    assign sz       = size_e'(size_in);
    assign off      = addr_in[1:0];
    assign aligned  = is_aligned(sz, off);
    assign access   = re_in | we_in;
    assign do_store = we_in & aligned;
    assign do_load  = re_in & ~we_in & aligned;

    assign in_ram = (addr_in[31:AW+2] == '0);
    assign tx_hit = (addr_in == SERIAL_TX_ADDR);
    assign rx_hit = (addr_in == SERIAL_RX_ADDR);
    assign st_hit = (addr_in == SERIAL_ST_ADDR);
    assign widx   = addr_in[AW+1:2];
    assign ram_we = do_store & in_ram;

    // Stall depends only on occupancy: a pop in the same cycle does not free a slot.
    assign stall_out = do_store & tx_hit & fifo_full;
    assign fifo_push = do_store & tx_hit & ~fifo_full;
    assign fifo_pop  = ~fifo_empty & serial_ready_in;

    assign status = {16'b0, 8'(fifo_count), 5'b0, fifo_empty, fifo_full, serial_valid_in};

    // Lane enables and lane data for a right-justified store of the given size.
    always_comb begin
        be = 4'b0000;
        for (int i = 0; i < 4; i++) wbyte[i] = writedata_in[7:0];
        case (sz)
            SZ_BYTE: begin
                be[off] = 1'b1;
            end
            SZ_HALF: begin
                be       = off[1] ? 4'b1100 : 4'b0011;
                wbyte[0] = writedata_in[15:8];
                wbyte[2] = writedata_in[15:8];
            end
            default: begin
                be       = 4'b1111;
                wbyte[0] = writedata_in[31:24];
                wbyte[1] = writedata_in[23:16];
                wbyte[2] = writedata_in[15:8];
            end
        endcase
    end

    // Byte-enabled RAM writes; contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we && be[0]) lane0[widx] <= wbyte[0];
        if (ram_we && be[1]) lane1[widx] <= wbyte[1];
        if (ram_we && be[2]) lane2[widx] <= wbyte[2];
        if (ram_we && be[3]) lane3[widx] <= wbyte[3];
    end

    assign rb0 = lane0[widx];
    assign rb1 = lane1[widx];
    assign rb2 = lane2[widx];
    assign rb3 = lane3[widx];

    // Select and right-justify the load result; unmapped addresses read zero.
    always_comb begin
        load_data = '0;
        if (in_ram) begin
            case (sz)
                SZ_BYTE: begin
                    case (off)
                        2'd0:    load_data = {24'b0, rb0};
                        2'd1:    load_data = {24'b0, rb1};
                        2'd2:    load_data = {24'b0, rb2};
                        default: load_data = {24'b0, rb3};
                    endcase
                end
                SZ_HALF: load_data = off[1] ? {16'b0, rb2, rb3} : {16'b0, rb0, rb1};
                default: load_data = {rb0, rb1, rb2, rb3};
            endcase
        end else if (rx_hit) begin
            load_data = serial_valid_in ? {24'b0, serial_in} : 32'hFFFF_FFFF;
        end else if (st_hit) begin
            load_data = status;
        end
    end

    // Load result register, misalignment pulse and RX consume pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readdata_out    <= '0;
            misalign_out    <= 1'b0;
            serial_rden_out <= 1'b0;
        end else begin
            misalign_out    <= access & ~aligned;
            serial_rden_out <= do_load & rx_hit & serial_valid_in;
            if (access && !aligned) begin
                readdata_out <= '0;
            end else if (do_load) begin
                readdata_out <= load_data;
            end
        end
    end

    // TX drain: hand one queued byte per cycle to the serial sink when it is ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            serial_out      <= '0;
            serial_wren_out <= 1'b0;
        end else begin
            serial_wren_out <= fifo_pop;
            if (fifo_pop) serial_out <= fifo_head;
        end
    end

    serial_tx_fifo #(
        .DEPTH  (TX_FIFO_DEPTH),
        .DATA_W (8),
        .CW     (CW)
    ) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (writedata_in[7:0]),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_data_memory_sized.sv
// Bench for data_memory_sized: directed steps followed by random sized
// accesses checked against a byte-array model of the memory.
module tb_data_memory_sized;

    localparam logic [31:0] TX_A = 32'hFFFF_0000;
    localparam logic [31:0] RX_A = 32'hFFFF_0004;
    localparam logic [31:0] ST_A = 32'hFFFF_0008;
    localparam logic [31:0] RBASE = 32'h0000_0100;

    logic        clock;
    logic        reset;
    logic [31:0] addr_in;
    logic [31:0] writedata_in;
    logic        re_in;
    logic        we_in;
    logic [1:0]  size_in;
    logic [31:0] readdata_out;
    logic        stall_out;
    logic        misalign_out;
    logic [7:0]  serial_in;
    logic        serial_ready_in;
    logic        serial_valid_in;
    logic [7:0]  serial_out;
    logic        serial_rden_out;
    logic        serial_wren_out;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  ref_mem [256];
    logic [7:0]  tx_bytes [9];

    data_memory_sized dut (
        .clock           (clock),
        .reset           (reset),
        .addr_in         (addr_in),
        .writedata_in    (writedata_in),
        .re_in           (re_in),
        .we_in           (we_in),
        .size_in         (size_in),
        .readdata_out    (readdata_out),
        .stall_out       (stall_out),
        .misalign_out    (misalign_out),
        .serial_in       (serial_in),
        .serial_ready_in (serial_ready_in),
        .serial_valid_in (serial_valid_in),
        .serial_out      (serial_out),
        .serial_rden_out (serial_rden_out),
        .serial_wren_out (serial_wren_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic op(input logic w, input logic r, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
        we_in = w;
        re_in = r;
        size_in = sz;
        addr_in = a;
        writedata_in = d;
        tick();
        we_in = 1'b0;
        re_in = 1'b0;
    endtask

    initial begin
        int got;
        int n;
        int k;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] tmp;
        logic [31:0] exp_rd;
        logic        exp_mis;
        logic        w;
        logic        r;
        logic        unm;
        logic        al;

        tx_bytes = '{8'h48, 8'h69, 8'h2C, 8'h20, 8'h74, 8'h68, 8'h65, 8'h72, 8'h65};

        reset = 1'b0;
        addr_in = '0;
        writedata_in = '0;
        re_in = 1'b0;
        we_in = 1'b0;
        size_in = 2'b11;
        serial_in = '0;
        serial_ready_in = 1'b0;
        serial_valid_in = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_readdata", readdata_out, 32'h0);
        check("rst_misalign", 32'(misalign_out), 32'h0);
        check("rst_serial_out", 32'(serial_out), 32'h0);
        check("rst_wren", 32'(serial_wren_out), 32'h0);
        check("rst_rden", 32'(serial_rden_out), 32'h0);
        reset = 1'b1;
        tick();

        // Word store then load
        op(1, 0, 2'b11, 32'h10, 32'hDEAD_BEEF);
        op(0, 1, 2'b11, 32'h10, 32'h0);
        check("word_load", readdata_out, 32'hDEAD_BEEF);
        check("word_load_mis", 32'(misalign_out), 32'h0);

        // Byte store over the word
        op(1, 0, 2'b00, 32'h13, 32'h0000_00AA);
        op(0, 1, 2'b00, 32'h13, 32'h0);
        check("byte_load", readdata_out, 32'h0000_00AA);
        op(0, 1, 2'b11, 32'h10, 32'h0);
        check("word_after_byte", readdata_out, 32'hDEAD_BEAA);

        // Misaligned half load
        op(0, 1, 2'b01, 32'h11, 32'h0);
        check("misalign_pulse", 32'(misalign_out), 32'h1);
        check("misalign_rd", readdata_out, 32'h0);
        tick();
        check("misalign_clear", 32'(misalign_out), 32'h0);
        check("hold_no_re", readdata_out, 32'h0);
        op(0, 1, 2'b11, 32'h10, 32'h0);
        check("ram_unchanged", readdata_out, 32'hDEAD_BEAA);

        // Store and load together: store wins, readdata holds
        op(1, 1, 2'b11, 32'h20, 32'h1234_5678);
        check("rw_hold", readdata_out, 32'hDEAD_BEAA);
        op(0, 1, 2'b11, 32'h20, 32'h0);
        check("rw_stored", readdata_out, 32'h1234_5678);

        // Half accesses
        op(1, 0, 2'b01, 32'h22, 32'h0000_BEEF);
        op(0, 1, 2'b11, 32'h20, 32'h0);
        check("half_store_word", readdata_out, 32'h1234_BEEF);
        op(0, 1, 2'b01, 32'h22, 32'h0);
        check("half_load_hi", readdata_out, 32'h0000_BEEF);
        op(0, 1, 2'b01, 32'h20, 32'h0);
        check("half_load_lo", readdata_out, 32'h0000_1234);
        op(0, 1, 2'b00, 32'h21, 32'h0);
        check("byte_load_1", readdata_out, 32'h0000_0034);

        // Unmapped: store ignored (no alias onto 0x20), load returns 0
        op(1, 0, 2'b11, 32'h1020, 32'hCAFE_F00D);
        op(0, 1, 2'b11, 32'h1020, 32'h0);
        check("unmapped_load", readdata_out, 32'h0);
        op(0, 1, 2'b11, 32'h20, 32'h0);
        check("no_alias", readdata_out, 32'h1234_BEEF);

        // TX FIFO fill with sink not ready
        serial_ready_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            we_in = 1'b1;
            size_in = 2'b00;
            addr_in = TX_A;
            writedata_in = {24'h0, tx_bytes[i]};
            #1;
            check("tx_fill_stall", 32'(stall_out), 32'h0);
            tick();
        end
        writedata_in = {24'h0, tx_bytes[8]};
        #1;
        check("tx_full_stall", 32'(stall_out), 32'h1);
        tick();
        check("tx_full_stall_held", 32'(stall_out), 32'h1);
        check("tx_no_wren", 32'(serial_wren_out), 32'h0);
        we_in = 1'b0;
        op(0, 1, 2'b11, ST_A, 32'h0);
        check("status_full", readdata_out, 32'h0000_0802);

        // Drain while the 9th store is still held
        we_in = 1'b1;
        size_in = 2'b00;
        addr_in = TX_A;
        writedata_in = {24'h0, tx_bytes[8]};
        serial_ready_in = 1'b1;
        #1;
        check("stall_before_pop", 32'(stall_out), 32'h1);
        tick();
        got = 0;
        check("tx_first_wren", 32'(serial_wren_out), 32'h1);
        check("tx_first_byte", 32'(serial_out), 32'(tx_bytes[0]));
        got = 1;
        check("stall_after_pop", 32'(stall_out), 32'h0);
        tick();
        we_in = 1'b0;
        check("tx_second_wren", 32'(serial_wren_out), 32'h1);
        check("tx_second_byte", 32'(serial_out), 32'(tx_bytes[1]));
        got = 2;
        for (int c = 0; c < 30 && got < 9; c++) begin
            tick();
            if (serial_wren_out) begin
                check("tx_order", 32'(serial_out), 32'(tx_bytes[got]));
                got++;
            end
        end
        check("tx_all_bytes", 32'(got), 32'd9);
        tick();
        check("tx_wren_drop", 32'(serial_wren_out), 32'h0);
        op(0, 1, 2'b11, ST_A, 32'h0);
        check("status_empty", readdata_out, 32'h0000_0004);

        // RX port
        serial_valid_in = 1'b1;
        serial_in = 8'h41;
        op(0, 1, 2'b11, RX_A, 32'h0);
        check("rx_data", readdata_out, 32'h0000_0041);
        check("rx_rden", 32'(serial_rden_out), 32'h1);
        op(0, 1, 2'b11, ST_A, 32'h0);
        check("rx_rden_pulse", 32'(serial_rden_out), 32'h0);
        check("status_valid", readdata_out, 32'h0000_0005);
        serial_valid_in = 1'b0;
        op(0, 1, 2'b11, RX_A, 32'h0);
        check("rx_none", readdata_out, 32'hFFFF_FFFF);
        check("rx_no_rden", 32'(serial_rden_out), 32'h0);

        // Reset discards queued TX bytes, RAM retained
        serial_ready_in = 1'b0;
        op(1, 0, 2'b00, TX_A, 32'h61);
        op(1, 0, 2'b00, TX_A, 32'h62);
        op(1, 0, 2'b00, TX_A, 32'h63);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_wren", 32'(serial_wren_out), 32'h0);
        check("rst_async_rd", readdata_out, 32'h0);
        serial_ready_in = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_no_wren", 32'(serial_wren_out), 32'h0);
        end
        op(0, 1, 2'b11, ST_A, 32'h0);
        check("rst_status", readdata_out, 32'h0000_0004);
        op(0, 1, 2'b11, 32'h10, 32'h0);
        check("rst_ram_kept", readdata_out, 32'hDEAD_BEAA);
        serial_ready_in = 1'b0;

        // Random phase: fill a region, then mixed sized accesses
        for (int i = 0; i < 64; i++) begin
            d = $urandom;
            op(1, 0, 2'b11, RBASE + 32'(4 * i), d);
            ref_mem[4*i]   = d[31:24];
            ref_mem[4*i+1] = d[23:16];
            ref_mem[4*i+2] = d[15:8];
            ref_mem[4*i+3] = d[7:0];
        end
        op(0, 1, 2'b11, RBASE, 32'h0);
        exp_rd = {ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]};
        check("rand_first", readdata_out, exp_rd);

        for (int it = 0; it < 300; it++) begin
            k = $urandom_range(0, 3);
            sz = k[1:0];
            n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            unm = ($urandom_range(0, 7) == 0);
            a = (unm ? 32'h0000_4000 : RBASE) + 32'($urandom_range(0, 255));
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = $urandom;
            al = ((a % n) == 0);
            exp_mis = (w | r) & ~al;
            if ((w | r) && !al) begin
                exp_rd = 32'h0;
            end else if (w) begin
                if (!unm) begin
                    for (int i = 0; i < n; i++) begin
                        tmp = d >> (8 * (n - 1 - i));
                        ref_mem[a - RBASE + 32'(i)] = tmp[7:0];
                    end
                end
            end else if (r) begin
                exp_rd = 32'h0;
                if (!unm) begin
                    for (int i = 0; i < n; i++)
                        exp_rd = (exp_rd << 8) | 32'(ref_mem[a - RBASE + 32'(i)]);
                end
            end
            op(w, r, sz, a, d);
            check("rand_rd", readdata_out, exp_rd);
            check("rand_mis", 32'(misalign_out), 32'(exp_mis));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
